// File: rtl/regfile_wb_pkg.sv
// Shared sizing defaults for the operand-stage register file and its write-back path.
package regfile_wb_pkg;
  localparam int DEF_WIDTH = 16;
  localparam int DEF_NREG  = 8;
  localparam int DEF_AW    = 3;
endpackage

// File: rtl/regfile_wb_array.sv
// NREG x WIDTH register storage: async clear, one synchronous write port, two async read ports.
module regfile_wb_array
  import regfile_wb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             i_we,
  input  logic [AW-1:0]    i_wa,
  input  logic [WIDTH-1:0] i_wd,
  input  logic [AW-1:0]    i_ra_a,
  input  logic [AW-1:0]    i_ra_b,
  output logic [WIDTH-1:0] o_rd_a,
  output logic [WIDTH-1:0] o_rd_b
);

  logic [WIDTH-1:0] r_mem [NREG];

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NREG; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_wa] <= i_wd;
    end
  end

  assign o_rd_a = r_mem[i_ra_a];
  assign o_rd_b = r_mem[i_ra_b];

endmodule

// File: rtl/regfile_wb.sv
// Operand stage: register file, one-cycle destination pipeline aligned to the
// function unit latency, and a write-back bypass onto both read ports.
module regfile_wb
  import regfile_wb_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREG  = DEF_NREG,
  parameter int AW    = DEF_AW
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [AW-1:0]    AA,
  input  logic [AW-1:0]    BA,
  input  logic [AW-1:0]    DA,
  input  logic             RW,
  input  logic             MB,
  input  logic             HOLD,
  input  logic [WIDTH-1:0] CONST_IN,
  input  logic [WIDTH-1:0] D_IN,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             WB_VALID,
  output logic [AW-1:0]    WB_ADDR
);

  logic             r_wb_valid;
  logic [AW-1:0]    r_wb_addr;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;
  logic             w_byp_a;
  logic             w_byp_b;

  // D_IN belongs to the op issued last cycle, so its destination is tracked one stage behind.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_wb_valid <= 1'b0;
      r_wb_addr  <= '0;
    end else begin
      r_wb_valid <= RW & ~HOLD;
      r_wb_addr  <= DA;
    end
  end

  regfile_wb_array #(
    .WIDTH(WIDTH),
    .NREG (NREG),
    .AW   (AW)
  ) u_array (
    .CLK   (CLK),
    .RESET (RESET),
    .i_we  (r_wb_valid),
    .i_wa  (r_wb_addr),
    .i_wd  (D_IN),
    .i_ra_a(AA),
    .i_ra_b(BA),
    .o_rd_a(w_rd_a),
    .o_rd_b(w_rd_b)
  );

  assign w_byp_a = r_wb_valid && (r_wb_addr == AA);
  assign w_byp_b = r_wb_valid && (r_wb_addr == BA);

  assign A        = w_byp_a ? D_IN : w_rd_a;
  assign B        = MB ? CONST_IN : (w_byp_b ? D_IN : w_rd_b);
  assign WB_VALID = r_wb_valid;
  assign WB_ADDR  = r_wb_addr;

endmodule
